// File: rtl/multicycle_cpu_controller.sv
// Multi-cycle MIPS control FSM: sequences each instruction over 3-5 states, stalls on memReady,
// traps illegal encodings (sticky flag) and counts retired instructions.
module multicycle_cpu_controller #(
    parameter int OPC_W  = 6,
    parameter int FUNC_W = 6,
    parameter int CNT_W  = 32,
    parameter int BNE_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPC_W-1:0]  opc,
    input  logic [FUNC_W-1:0] func,
    input  logic              zero,
    input  logic              memReady,
    output logic              pcLoad,
    output logic              iOrD,
    output logic              memRead,
    output logic              memWrite,
    output logic              irWrite,
    output logic [1:0]        regDst,
    output logic [1:0]        memToReg,
    output logic              regWrite,
    output logic              aluSrcA,
    output logic [1:0]        aluSrcB,
    output logic [2:0]        aluCtrl,
    output logic [1:0]        pcSrc,
    output logic              illegal,
    output logic [CNT_W-1:0]  instrCount
);

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_SLTI  = OPC_W'(6'b001010);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(6'b000101);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'(6'b000011);
    localparam logic [OPC_W-1:0] OP_JR    = OPC_W'(6'b111111);

    localparam logic [FUNC_W-1:0] FN_ADD = FUNC_W'(6'b100000);
    localparam logic [FUNC_W-1:0] FN_SUB = FUNC_W'(6'b100010);
    localparam logic [FUNC_W-1:0] FN_AND = FUNC_W'(6'b100100);
    localparam logic [FUNC_W-1:0] FN_OR  = FUNC_W'(6'b100101);
    localparam logic [FUNC_W-1:0] FN_SLT = FUNC_W'(6'b101010);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EX_R, S_WB_R, S_EX_I, S_WB_I, S_MEM_ADDR, S_MEM_RD,
        S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_TRAP
    } state_t;

    state_t             state, state_next;
    logic [OPC_W-1:0]   opc_q;
    logic [FUNC_W-1:0]  func_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            opc_q      <= '0;
            func_q     <= '0;
            illegal    <= 1'b0;
            instrCount <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                opc_q  <= opc;
                func_q <= func;
            end
            if (state_next == S_TRAP)
                illegal <= 1'b1;
            // TRAP never leaves on its own, so the counter freezes there.
            if (state != S_FETCH && state_next == S_FETCH)
                instrCount <= instrCount + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        pcLoad     = 1'b0;
        iOrD       = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regDst     = 2'b00;
        memToReg   = 2'b00;
        regWrite   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        aluCtrl    = 3'b000;
        pcSrc      = 2'b00;
        case (state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                aluCtrl = ALU_ADD;
                irWrite = memReady;
                pcLoad  = memReady;
                if (memReady)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                aluSrcB = 2'b11;
                aluCtrl = ALU_ADD;
                case (opc)
                    OP_RTYPE:        state_next = S_EX_R;
                    OP_ADDI, OP_SLTI: state_next = S_EX_I;
                    OP_LW, OP_SW:    state_next = S_MEM_ADDR;
                    OP_BEQ:          state_next = S_BRANCH;
                    OP_BNE:          state_next = (BNE_EN != 0) ? S_BRANCH : S_TRAP;
                    OP_J:            state_next = S_JUMP;
                    OP_JAL:          state_next = S_JAL;
                    OP_JR:           state_next = S_JR;
                    default:         state_next = S_TRAP;
                endcase
            end
            S_EX_R: begin
                aluSrcA    = 1'b1;
                state_next = S_WB_R;
                case (func_q)
                    FN_ADD:  aluCtrl = ALU_ADD;
                    FN_SUB:  aluCtrl = ALU_SUB;
                    FN_AND:  aluCtrl = ALU_AND;
                    FN_OR:   aluCtrl = ALU_OR;
                    FN_SLT:  aluCtrl = ALU_SLT;
                    default: state_next = S_TRAP;
                endcase
            end
            S_WB_R: begin
                regDst     = 2'b01;
                regWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_EX_I: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluCtrl    = (opc_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_next = S_WB_I;
            end
            S_WB_I: begin
                regWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluCtrl    = ALU_ADD;
                state_next = (opc_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                memRead = 1'b1;
                iOrD    = 1'b1;
                if (memReady)
                    state_next = S_WB_LW;
            end
            S_WB_LW: begin
                memToReg   = 2'b01;
                regWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                memWrite = 1'b1;
                iOrD     = 1'b1;
                if (memReady)
                    state_next = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                aluCtrl    = ALU_SUB;
                pcSrc      = 2'b01;
                pcLoad     = (opc_q == OP_BNE) ? ~zero : zero;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pcSrc      = 2'b10;
                pcLoad     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                pcSrc      = 2'b10;
                pcLoad     = 1'b1;
                regDst     = 2'b10;
                memToReg   = 2'b10;
                regWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_JR: begin
                pcSrc      = 2'b11;
                pcLoad     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_cpu_controller.sv
// Directed bench: cycle-by-cycle control-word checks for every instruction class, stalls, traps, wrap.
module tb_multicycle_cpu_controller;

    // Control word order: pcLoad iOrD memRead memWrite irWrite regDst memToReg regWrite aluSrcA aluSrcB aluCtrl pcSrc
    localparam logic [17:0] W_FETCH       = 18'b1_0_1_0_1_00_00_0_0_01_010_00;
    localparam logic [17:0] W_FETCH_STALL = 18'b0_0_1_0_0_00_00_0_0_01_010_00;
    localparam logic [17:0] W_DECODE      = 18'b0_0_0_0_0_00_00_0_0_11_010_00;
    localparam logic [17:0] W_MEM_ADDR    = 18'b0_0_0_0_0_00_00_0_1_10_010_00;
    localparam logic [17:0] W_MEM_RD      = 18'b0_1_1_0_0_00_00_0_0_00_000_00;
    localparam logic [17:0] W_MEM_WR      = 18'b0_1_0_1_0_00_00_0_0_00_000_00;
    localparam logic [17:0] W_WB_R        = 18'b0_0_0_0_0_01_00_1_0_00_000_00;
    localparam logic [17:0] W_WB_I        = 18'b0_0_0_0_0_00_00_1_0_00_000_00;
    localparam logic [17:0] W_WB_LW       = 18'b0_0_0_0_0_00_01_1_0_00_000_00;
    localparam logic [17:0] W_J           = 18'b1_0_0_0_0_00_00_0_0_00_000_10;
    localparam logic [17:0] W_JAL         = 18'b1_0_0_0_0_10_10_1_0_00_000_10;
    localparam logic [17:0] W_JR          = 18'b1_0_0_0_0_00_00_0_0_00_000_11;
    localparam logic [17:0] W_TRAP        = 18'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic [5:0] opc, func;
    logic       zero, memReady;

    logic pcLoad, iOrD, memRead, memWrite, irWrite, regWrite, aluSrcA, illegal;
    logic [1:0] regDst, memToReg, aluSrcB, pcSrc;
    logic [2:0] aluCtrl;
    logic [31:0] instrCount;

    logic pcLoad_b, iOrD_b, memRead_b, memWrite_b, irWrite_b, regWrite_b, aluSrcA_b, illegal_b;
    logic [1:0] regDst_b, memToReg_b, aluSrcB_b, pcSrc_b;
    logic [2:0] aluCtrl_b;
    logic [31:0] instrCount_b;

    logic pcLoad_c, iOrD_c, memRead_c, memWrite_c, irWrite_c, regWrite_c, aluSrcA_c, illegal_c;
    logic [1:0] regDst_c, memToReg_c, aluSrcB_c, pcSrc_c;
    logic [2:0] aluCtrl_c;
    logic [3:0] instrCount_c;

    multicycle_cpu_controller dut (
        .clk(clk), .rst(rst_a), .opc(opc), .func(func), .zero(zero), .memReady(memReady),
        .pcLoad(pcLoad), .iOrD(iOrD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluCtrl(aluCtrl), .pcSrc(pcSrc), .illegal(illegal), .instrCount(instrCount)
    );

    multicycle_cpu_controller #(.BNE_EN(0)) dut_nobne (
        .clk(clk), .rst(rst_b), .opc(opc), .func(func), .zero(zero), .memReady(memReady),
        .pcLoad(pcLoad_b), .iOrD(iOrD_b), .memRead(memRead_b), .memWrite(memWrite_b), .irWrite(irWrite_b),
        .regDst(regDst_b), .memToReg(memToReg_b), .regWrite(regWrite_b), .aluSrcA(aluSrcA_b),
        .aluSrcB(aluSrcB_b), .aluCtrl(aluCtrl_b), .pcSrc(pcSrc_b), .illegal(illegal_b),
        .instrCount(instrCount_b)
    );

    multicycle_cpu_controller #(.CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst_c), .opc(opc), .func(func), .zero(zero), .memReady(memReady),
        .pcLoad(pcLoad_c), .iOrD(iOrD_c), .memRead(memRead_c), .memWrite(memWrite_c), .irWrite(irWrite_c),
        .regDst(regDst_c), .memToReg(memToReg_c), .regWrite(regWrite_c), .aluSrcA(aluSrcA_c),
        .aluSrcB(aluSrcB_c), .aluCtrl(aluCtrl_c), .pcSrc(pcSrc_c), .illegal(illegal_c),
        .instrCount(instrCount_c)
    );

    logic [17:0] obs, obs_b, obs_c;
    assign obs   = {pcLoad, iOrD, memRead, memWrite, irWrite, regDst, memToReg,
                    regWrite, aluSrcA, aluSrcB, aluCtrl, pcSrc};
    assign obs_b = {pcLoad_b, iOrD_b, memRead_b, memWrite_b, irWrite_b, regDst_b, memToReg_b,
                    regWrite_b, aluSrcA_b, aluSrcB_b, aluCtrl_b, pcSrc_b};
    assign obs_c = {pcLoad_c, iOrD_c, memRead_c, memWrite_c, irWrite_c, regDst_c, memToReg_c,
                    regWrite_c, aluSrcA_c, aluSrcB_c, aluCtrl_c, pcSrc_c};

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_count = 32'd0;

    // Every task starts and ends on a falling edge with the controller sitting in FETCH.
    task automatic test_reset();
        rst_a = 1'b1; memReady = 1'b0; opc = 6'b0; func = 6'b0; zero = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs !== W_FETCH_STALL) begin
                failures++;
                $display("FAIL reset_fetch_stall cyc=%0d got=%b want=%b", i, obs, W_FETCH_STALL);
            end
            checks++;
            if (illegal !== 1'b0 || instrCount !== 32'd0) begin
                failures++;
                $display("FAIL reset_state illegal=%b count=%0d want 0/0", illegal, instrCount);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        logic [17:0] exp [4];
        logic [5:0]  fn;
        logic [2:0]  ac;
        for (int f = 0; f < 5; f++) begin
            case (f)
                0: begin fn = 6'b100000; ac = 3'b010; end
                1: begin fn = 6'b100010; ac = 3'b011; end
                2: begin fn = 6'b100100; ac = 3'b000; end
                3: begin fn = 6'b100101; ac = 3'b001; end
                default: begin fn = 6'b101010; ac = 3'b100; end
            endcase
            exp[0] = W_FETCH; exp[1] = W_DECODE;
            exp[2] = {13'b0_0_0_0_0_00_00_0_1_00, ac, 2'b00};
            exp[3] = W_WB_R;
            opc = 6'b000000; func = fn; memReady = 1'b1;
            for (int i = 0; i < 4; i++) begin
                // Scramble the IR fields after DECODE: later states must use the latched copy.
                if (i >= 2) begin opc = 6'b010101; func = 6'b000111; end
                #1;
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL rtype f=%b cyc=%0d got=%b want=%b", fn, i, obs, exp[i]);
                end
                @(negedge clk);
            end
            exp_count++;
            checks++;
            if (instrCount !== exp_count) begin
                failures++;
                $display("FAIL rtype_count got=%0d want=%0d", instrCount, exp_count);
            end
        end
    endtask

    task automatic test_lw_stall();
        logic [17:0] exp [8];
        logic        rdy [8];
        exp[0] = W_FETCH; exp[1] = W_DECODE; exp[2] = W_MEM_ADDR;
        exp[3] = W_MEM_RD; exp[4] = W_MEM_RD; exp[5] = W_MEM_RD; exp[6] = W_MEM_RD; exp[7] = W_WB_LW;
        rdy[0] = 1; rdy[1] = 1; rdy[2] = 1; rdy[3] = 0; rdy[4] = 0; rdy[5] = 0; rdy[6] = 1; rdy[7] = 1;
        opc = 6'b100011; func = 6'b0;
        for (int i = 0; i < 8; i++) begin
            memReady = rdy[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL lw_stall cyc=%0d got=%b want=%b", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        memReady = 1'b1;
        exp_count++;
        checks++;
        if (instrCount !== exp_count) begin
            failures++;
            $display("FAIL lw_latency count=%0d want=%0d", instrCount, exp_count);
        end
    endtask

    task automatic test_branch();
        logic [17:0] exp [3];
        logic        pl;
        for (int k = 0; k < 4; k++) begin
            opc  = (k < 2) ? 6'b000100 : 6'b000101;
            zero = (k % 2 == 0);
            pl   = (k < 2) ? zero : ~zero;
            exp[0] = W_FETCH; exp[1] = W_DECODE;
            exp[2] = {pl, 12'b0_0_0_0_00_00_0_1_00, 3'b011, 2'b01};
            memReady = 1'b1;
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL branch opc=%b zero=%b cyc=%0d got=%b want=%b", opc, zero, i, obs, exp[i]);
                end
                @(negedge clk);
            end
            exp_count++;
            checks++;
            if (instrCount !== exp_count) begin
                failures++;
                $display("FAIL branch_count got=%0d want=%0d", instrCount, exp_count);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jumps();
        logic [17:0] exp [3];
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin opc = 6'b000010; exp[2] = W_J;   end
                1: begin opc = 6'b000011; exp[2] = W_JAL; end
                default: begin opc = 6'b111111; exp[2] = W_JR; end
            endcase
            exp[0] = W_FETCH; exp[1] = W_DECODE;
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL jump opc=%b cyc=%0d got=%b want=%b", opc, i, obs, exp[i]);
                end
                @(negedge clk);
            end
            exp_count++;
            checks++;
            if (instrCount !== exp_count) begin
                failures++;
                $display("FAIL jump_count opc=%b got=%0d want=%0d", opc, instrCount, exp_count);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp [4];
        for (int k = 0; k < 3; k++) begin
            exp[0] = W_FETCH; exp[1] = W_DECODE;
            case (k)
                0: begin opc = 6'b001000; exp[2] = {13'b0_0_0_0_0_00_00_0_1_10, 3'b010, 2'b00}; exp[3] = W_WB_I; end
                1: begin opc = 6'b001010; exp[2] = {13'b0_0_0_0_0_00_00_0_1_10, 3'b100, 2'b00}; exp[3] = W_WB_I; end
                default: begin opc = 6'b101011; exp[2] = W_MEM_ADDR; exp[3] = W_MEM_WR; end
            endcase
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL b2b opc=%b cyc=%0d got=%b want=%b", opc, i, obs, exp[i]);
                end
                @(negedge clk);
            end
            exp_count++;
            checks++;
            if (instrCount !== exp_count) begin
                failures++;
                $display("FAIL b2b_count opc=%b got=%0d want=%0d", opc, instrCount, exp_count);
            end
        end
    endtask

    task automatic test_illegal();
        opc = 6'b010101; func = 6'b0; memReady = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== W_TRAP || illegal !== 1'b1 || instrCount !== exp_count) begin
                failures++;
                $display("FAIL trap_opc cyc=%0d word=%b illegal=%b count=%0d want word=0 illegal=1 count=%0d",
                         i, obs, illegal, instrCount, exp_count);
            end
            @(negedge clk);
        end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        exp_count = 32'd0;
        #1;
        checks++;
        if (obs !== W_FETCH || illegal !== 1'b0 || instrCount !== 32'd0) begin
            failures++;
            $display("FAIL trap_reset word=%b illegal=%b count=%0d want fetch/0/0", obs, illegal, instrCount);
        end
        opc = 6'b000000; func = 6'b000111;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs !== W_TRAP || illegal !== 1'b1 || instrCount !== 32'd0) begin
            failures++;
            $display("FAIL trap_funct word=%b illegal=%b count=%0d want 0/1/0", obs, illegal, instrCount);
        end
        @(negedge clk);
        rst_a = 1'b1;
    endtask

    task automatic test_bne_disabled();
        rst_b = 1'b0; opc = 6'b000101; zero = 1'b1; memReady = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs_b !== W_TRAP || illegal_b !== 1'b1 || instrCount_b !== 32'd0) begin
            failures++;
            $display("FAIL bne_disabled word=%b illegal=%b count=%0d want 0/1/0", obs_b, illegal_b, instrCount_b);
        end
        @(negedge clk);
        rst_b = 1'b1; zero = 1'b0;
    endtask

    task automatic test_counter_wrap();
        logic [3:0] exp4 = 4'd0;
        rst_c = 1'b0; opc = 6'b000010; memReady = 1'b1;
        for (int k = 0; k < 16; k++) begin
            repeat (2) @(negedge clk);
            #1;
            checks++;
            if (obs_c !== W_J) begin
                failures++;
                $display("FAIL wrap_jump k=%0d got=%b want=%b", k, obs_c, W_J);
            end
            @(negedge clk);
            exp4 = exp4 + 4'd1;
            checks++;
            if (instrCount_c !== exp4) begin
                failures++;
                $display("FAIL wrap_count k=%0d got=%0d want=%0d", k, instrCount_c, exp4);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        opc = 6'b101011; memReady = 1'b1;
        repeat (3) @(negedge clk);
        memReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs_c !== W_MEM_WR) begin
                failures++;
                $display("FAIL sw_stall_hold cyc=%0d got=%b want=%b", i, obs_c, W_MEM_WR);
            end
            @(negedge clk);
        end
        rst_c = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (memWrite_c !== 1'b0 || obs_c !== W_FETCH_STALL || instrCount_c !== 4'd0) begin
            failures++;
            $display("FAIL sw_reset word=%b count=%0d want %b/0", obs_c, instrCount_c, W_FETCH_STALL);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        opc = 6'b0; func = 6'b0; zero = 1'b0; memReady = 1'b0;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_illegal();
        test_bne_disabled();
        test_counter_wrap();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu_controller.md
Name: multicycle_cpu_controller

Overview:
- FSM control unit for the multi-cycle MIPS datapath. It is the next generation of the single-cycle decoder: instructions are sequenced over 3–5 states, and memory accesses stall on a ready handshake.
- Supports R-type (add/sub/and/or/slt), addi, slti, lw, sw, j, jal, jr, beq, plus new bne.
- Adds an illegal-instruction trap and a retired-instruction counter.
- Sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
- OPC_W, 6, opcode width.
- FUNC_W, 6, funct width.
- CNT_W, 32, width of retired-instruction counter.
- BNE_EN, 1, 1 = decode bne (opcode 000101); 0 = treat it as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opc  in  OPC_W  opcode from IR.
- func  in  FUNC_W  funct from IR.
- zero  in  1  ALU zero flag.
- memReady  in  1  memory access completes this cycle; tie high for 1-cycle memory.
- pcLoad  out  1  PC write enable (branch condition already folded in).
- iOrD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- irWrite  out  1  IR load.
- regDst  out  2  write register select: 00 = rt, 01 = rd, 10 = r31.
- memToReg  out  2  write-back data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- regWrite  out  1  register file write.
- aluSrcA  out  1  0 = PC, 1 = A.
- aluSrcB  out  2  00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
- aluCtrl  out  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT.
- pcSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A.
- illegal  out  1  sticky trap flag.
- instrCount  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- On reset: state = FETCH, illegal = 0, instrCount = 0, latched opcode/funct = 0. rst overrides any state mid-instruction.
- Outputs are Moore functions of state (plus zero and memReady where noted). Any signal not listed for a state is 0.
- FETCH:
  - memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluCtrl=ADD, pcSrc=00.
  - irWrite = pcLoad = memReady.
  - Stay in FETCH while memReady=0; go to DECODE when memReady=1.
- DECODE:
  - aluSrcA=0, aluSrcB=11, aluCtrl=ADD (precomputes the branch target).
  - Latch opc/func into internal registers; all later states use the latched copies.
  - Next state by opcode: 000000 → EX_R; 001000/001010 → EX_I; 100011/101011 → MEM_ADDR; 000100 → BRANCH; 000101 → BRANCH if BNE_EN, else TRAP; 000010 → JUMP; 000011 → JAL; 111111 → JR; anything else → TRAP.
- EX_R: aluSrcA=1, aluSrcB=00; aluCtrl from funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT). Unknown funct goes to TRAP instead of WB_R.
- WB_R: regDst=01, memToReg=00, regWrite=1. Next FETCH.
- EX_I: aluSrcA=1, aluSrcB=10; aluCtrl = ADD for addi, SLT for slti. Next WB_I.
- WB_I: regDst=00, memToReg=00, regWrite=1. Next FETCH.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluCtrl=ADD. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: memRead=1, iOrD=1. Hold while memReady=0; go to WB_LW when memReady=1.
- WB_LW: regDst=00, memToReg=01, regWrite=1. Next FETCH.
- MEM_WR: memWrite=1, iOrD=1. Hold while memReady=0; go to FETCH when memReady=1. The write strobe is held high for the entire stall.
- BRANCH:
  - aluSrcA=1, aluSrcB=00, aluCtrl=SUB, pcSrc=01.
  - pcLoad = zero for beq, !zero for bne.
  - Next FETCH.
- JUMP: pcSrc=10, pcLoad=1. Next FETCH.
- JAL: pcSrc=10, pcLoad=1, regDst=10, memToReg=10, regWrite=1 (the PC value written is still PC+4). Next FETCH.
- JR: pcSrc=11, pcLoad=1. Next FETCH.
- TRAP:
  - All strobes are 0.
  - illegal is set to 1 on entry.
  - Absorbing state; only rst exits it.
- Latency with memReady constantly 1: R/addi/slti/sw = 4 cycles; lw = 5; beq/bne/j/jal/jr = 3.
- instrCount:
  - +1 on every transition into FETCH from a non-FETCH state.
  - Wraps modulo 2^CNT_W.
  - Never increments in TRAP.
- Memory stalls: during a stall all outputs are held constant, except that pcLoad and irWrite stay 0 until memReady is high.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then memReady=1 with opc=000000 and func=100000 → sequence FETCH, DECODE, EX_R, WB_R, FETCH; aluCtrl=010 in EX_R; regWrite=1 only in WB_R; instrCount=1.
- lw with stall: opc=100011, memReady low for 3 cycles in MEM_RD → memRead and iOrD held at 1 for 4 cycles, then WB_LW with memToReg=01 and regWrite=1; total latency 8 cycles.
- Branch pair: beq with zero=1 → pcLoad=1 in BRANCH; bne (BNE_EN=1) with zero=1 → pcLoad=0; bne with BNE_EN=0 → TRAP and illegal=1.
- jal: opc=000011 → in the JAL cycle regDst=10, memToReg=10, regWrite=1, pcSrc=10, pcLoad=1; 3-cycle latency.
- Illegal encodings: opc=010101, and separately opc=0 with func=000111 → TRAP, illegal sticky, instrCount frozen; rst mid-TRAP → FETCH, illegal=0.
- Counter wrap: CNT_W=4 with 16 j instructions → instrCount returns to 0; rst asserted mid-MEM_WR → memWrite=0 on the next cycle, state = FETCH.
